// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the multiplier datapath
//
// Purpose: common constants and FSM state types used by the product accumulator.
//   DEF_PROD_W  : default product width coming from the 4x4 multiplier
//   acc_state_e : accumulator FSM (idle / block in progress)
//   out_state_e : output register FSM (empty / holding a result)
package mult_pkg;

    localparam int DEF_PROD_W = 8;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/valid_edge_detect.sv
// rtl/valid_edge_detect.sv - turns the product qualifier into a one-cycle accept strobe
//
// Purpose: registers in_valid every cycle and produces accept on its rising edge.
//   With EDGE_MODE=0 the edge logic is bypassed and accept follows in_valid.
// Ports:
//   clk       in   clock, posedge
//   rst       in   synchronous active-high reset (clears the history flop)
//   in_valid  in   product qualifier from the multiplier
//   accept    out  product accept strobe
module valid_edge_detect #(
    parameter int EDGE_MODE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic accept
);

    logic in_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
        end
    end

    // Clearing the history on reset means a qualifier already high when reset
    // drops is seen as a fresh edge.
    assign accept = (EDGE_MODE != 0) ? (in_valid & ~in_valid_q) : in_valid;

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums COUNT products per block onto a valid/ready result register
//
// Purpose: captures multiplier products, saturating-adds COUNT of them into one
//   block sum and hands the sum to a consumer through a valid/ready register.
//   The next block keeps accumulating while a result waits.
// Ports:
//   clk         in   clock, posedge
//   rst         in   synchronous active-high reset
//   in_product  in   product from multiplier (PROD_W)
//   in_valid    in   product qualifier (multiplier op_ready)
//   clear       in   abort the partial block; output register untouched
//   out_sum     out  block sum (ACC_W), stable while out_valid
//   out_valid   out  block sum available
//   out_ready   in   consumer accepts when out_valid & out_ready
//   busy        out  partial block in progress
//   overflow    out  sticky: some block saturated
//   in_drop     out  one-cycle pulse: completing product discarded, output full
module product_accumulator
    import mult_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int COUNT     = 4,
    parameter int ACC_W     = 12,
    parameter int EDGE_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_valid,
    input  logic              clear,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow,
    output logic              in_drop
);

    localparam int CNT_W = $clog2(COUNT);

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("product_accumulator: ACC_W must be >= PROD_W");
    end
    if (COUNT < 2) begin : g_bad_count
        $error("product_accumulator: COUNT must be >= 2");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic             accept;
    logic             take;
    logic             is_final;
    logic             out_free;
    logic             load;
    logic             drop;
    logic             step;
    acc_state_e       acc_state;
    out_state_e       out_state;

    valid_edge_detect #(
        .EDGE_MODE (EDGE_MODE)
    ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .accept   (accept)
    );

    // One extra bit catches the carry that triggers saturation.
    assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign sat      = sum_wide[ACC_W];
    assign sum      = sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

    // clear beats any same-cycle accept, so a cleared product never loads or drops.
    assign take     = accept & ~clear;
    assign is_final = (cnt == CNT_W'(COUNT - 1));
    assign out_free = (out_state == OUT_EMPTY) | out_ready;
    assign load     = take & is_final & out_free;
    assign drop     = take & is_final & ~out_free;
    assign step     = take & ~is_final;

    // A dropped final product leaves acc/cnt alone so the block completes on the next accept.
    always_comb begin
        cnt_next = cnt;
        acc_next = acc;
        if (clear || load) begin
            cnt_next = '0;
            acc_next = '0;
        end else if (step) begin
            cnt_next = cnt + CNT_W'(1);
            acc_next = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            acc_state <= ACC_IDLE;
            out_state <= OUT_EMPTY;
            out_sum   <= '0;
            overflow  <= 1'b0;
            in_drop   <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            acc       <= acc_next;
            acc_state <= (cnt_next != '0) ? ACC_RUN : ACC_IDLE;
            in_drop   <= drop;
            if ((load || step) && sat) begin
                overflow <= 1'b1;
            end
            // A load during a handoff keeps the register full with the new sum.
            if (load) begin
                out_sum   <= sum;
                out_state <= OUT_FULL;
            end else if (out_ready) begin
                out_state <= OUT_EMPTY;
            end
        end
    end

    assign busy      = (acc_state == ACC_RUN);
    assign out_valid = (out_state == OUT_FULL);

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic [7:0]  in_product;
    logic        in_valid;
    logic        clear;
    logic        out_ready;

    logic [11:0] a_sum;
    logic        a_valid, a_busy, a_ovf, a_drop;
    logic [8:0]  b_sum;
    logic        b_valid, b_busy, b_ovf, b_drop;
    logic [11:0] c_sum;
    logic        c_valid, c_busy, c_ovf, c_drop;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.PROD_W(8), .COUNT(4), .ACC_W(12), .EDGE_MODE(1)) dut (
        .clk(clk), .rst(rst), .in_product(in_product), .in_valid(in_valid), .clear(clear),
        .out_sum(a_sum), .out_valid(a_valid), .out_ready(out_ready), .busy(a_busy),
        .overflow(a_ovf), .in_drop(a_drop)
    );

    product_accumulator #(.PROD_W(8), .COUNT(4), .ACC_W(9), .EDGE_MODE(1)) dut9 (
        .clk(clk), .rst(rst), .in_product(in_product), .in_valid(in_valid), .clear(clear),
        .out_sum(b_sum), .out_valid(b_valid), .out_ready(out_ready), .busy(b_busy),
        .overflow(b_ovf), .in_drop(b_drop)
    );

    product_accumulator #(.PROD_W(8), .COUNT(4), .ACC_W(12), .EDGE_MODE(0)) dut_lvl (
        .clk(clk), .rst(rst), .in_product(in_product), .in_valid(in_valid), .clear(clear),
        .out_sum(c_sum), .out_valid(c_valid), .out_ready(out_ready), .busy(c_busy),
        .overflow(c_ovf), .in_drop(c_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  p0, p1, p2, p3;
        logic [11:0] sum12;
        logic [8:0]  sum9;
        logic        ovf9;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] p);
        in_product = p;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_product = '0;
        in_valid   = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b1;

        vecs[0] = '{8'd3,   8'd5,   8'd7,   8'd9,   12'd24,   9'd24,  1'b0};
        vecs[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   12'd0,    9'd0,   1'b0};
        vecs[2] = '{8'd100, 8'd200, 8'd50,  8'd1,   12'd351,  9'd351, 1'b0};
        vecs[3] = '{8'd200, 8'd200, 8'd100, 8'd11,  12'd511,  9'd511, 1'b0};
        vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   12'd511,  9'd511, 1'b0};
        vecs[5] = '{8'd255, 8'd255, 8'd2,   8'd0,   12'd512,  9'd511, 1'b1};
        vecs[6] = '{8'd255, 8'd255, 8'd255, 8'd255, 12'd1020, 9'd511, 1'b1};

        // Reset state
        do_reset();
        check("rst out_sum",   32'(a_sum),   0);
        check("rst out_valid", 32'(a_valid), 0);
        check("rst busy",      32'(a_busy),  0);
        check("rst overflow",  32'(a_ovf),   0);
        check("rst in_drop",   32'(a_drop),  0);

        // Table: one block per row, consumer always ready
        for (int i = 0; i < 7; i++) begin
            do_reset();
            out_ready = 1'b1;
            pulse(vecs[i].p0);
            pulse(vecs[i].p1);
            pulse(vecs[i].p2);
            check($sformatf("row%0d busy before final", i), 32'(a_busy), 1);
            check($sformatf("row%0d valid before final", i), 32'(a_valid), 0);
            in_product = vecs[i].p3;
            in_valid   = 1'b1;
            tick();
            check($sformatf("row%0d valid", i),    32'(a_valid), 1);
            check($sformatf("row%0d sum12", i),    32'(a_sum),   32'(vecs[i].sum12));
            check($sformatf("row%0d ovf12", i),    32'(a_ovf),   0);
            check($sformatf("row%0d sum9", i),     32'(b_sum),   32'(vecs[i].sum9));
            check($sformatf("row%0d ovf9", i),     32'(b_ovf),   32'(vecs[i].ovf9));
            check($sformatf("row%0d level sum", i), 32'(c_sum),  32'(vecs[i].sum12));
            check($sformatf("row%0d busy after", i), 32'(a_busy), 0);
            in_valid = 1'b0;
            tick();
            check($sformatf("row%0d valid 1clk", i), 32'(a_valid), 0);
            check($sformatf("row%0d sum held", i),   32'(a_sum),   32'(vecs[i].sum12));
            check($sformatf("row%0d ovf9 sticky", i), 32'(b_ovf),  32'(vecs[i].ovf9));
        end

        // in_valid held high 6 clocks: one accept in edge mode, six in level mode
        do_reset();
        out_ready  = 1'b1;
        in_product = 8'd2;
        in_valid   = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("held edge cnt",   32'(dut.cnt), 1);
        check("held edge busy",  32'(a_busy),  1);
        check("held edge valid", 32'(a_valid), 0);
        check("held level sum",  32'(c_sum),   8);
        check("held level cnt",  32'(dut_lvl.cnt), 2);
        check("held level valid", 32'(c_valid), 0);
        in_valid = 1'b0;
        tick();

        // Back-pressure: second block's final product is dropped
        do_reset();
        out_ready = 1'b0;
        repeat (4) pulse(8'd1);
        check("bp first valid", 32'(a_valid), 1);
        check("bp first sum",   32'(a_sum),   4);
        repeat (3) pulse(8'd1);
        in_product = 8'd1;
        in_valid   = 1'b1;
        tick();
        check("bp drop pulse",  32'(a_drop),  1);
        check("bp drop cnt",    32'(dut.cnt), 3);
        check("bp drop sum",    32'(a_sum),   4);
        check("bp drop valid",  32'(a_valid), 1);
        in_valid = 1'b0;
        tick();
        check("bp drop 1clk",   32'(a_drop),  0);
        out_ready = 1'b1;
        tick();
        check("bp handoff valid", 32'(a_valid), 0);
        check("bp handoff sum",   32'(a_sum),   4);
        in_valid = 1'b1;
        tick();
        check("bp second valid", 32'(a_valid), 1);
        check("bp second sum",   32'(a_sum),   4);
        check("bp second cnt",   32'(dut.cnt), 0);
        in_valid = 1'b0;
        tick();

        // Load in the same cycle as a handoff keeps the register full
        out_ready = 1'b0;
        repeat (4) pulse(8'd2);
        check("ho first sum", 32'(a_sum), 8);
        repeat (3) pulse(8'd3);
        out_ready  = 1'b1;
        in_product = 8'd3;
        in_valid   = 1'b1;
        tick();
        check("ho valid", 32'(a_valid), 1);
        check("ho sum",   32'(a_sum),   12);
        check("ho drop",  32'(a_drop),  0);
        in_valid = 1'b0;
        tick();

        // clear with a same-cycle accept
        do_reset();
        out_ready = 1'b1;
        pulse(8'd10);
        pulse(8'd20);
        check("clr pre cnt", 32'(dut.cnt), 2);
        in_product = 8'd30;
        in_valid   = 1'b1;
        clear      = 1'b1;
        tick();
        check("clr cnt",   32'(dut.cnt), 0);
        check("clr busy",  32'(a_busy),  0);
        check("clr drop",  32'(a_drop),  0);
        check("clr valid", 32'(a_valid), 0);
        in_valid = 1'b0;
        clear    = 1'b0;
        tick();
        pulse(8'd1);
        pulse(8'd2);
        pulse(8'd3);
        in_product = 8'd4;
        in_valid   = 1'b1;
        tick();
        check("clr block valid", 32'(a_valid), 1);
        check("clr block sum",   32'(a_sum),   10);
        in_valid = 1'b0;
        tick();

        // Reset mid-block with a pending result
        do_reset();
        out_ready = 1'b0;
        repeat (4) pulse(8'd1);
        pulse(8'd1);
        pulse(8'd1);
        check("mid pre valid", 32'(a_valid), 1);
        check("mid pre cnt",   32'(dut.cnt), 2);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        check("mid rst sum",   32'(a_sum),   0);
        check("mid rst valid", 32'(a_valid), 0);
        check("mid rst busy",  32'(a_busy),  0);
        check("mid rst ovf",   32'(a_ovf),   0);
        check("mid rst drop",  32'(a_drop),  0);
        check("mid rst q",     32'(dut.u_edge.in_valid_q), 0);
        rst = 1'b0;
        tick();
        check("post rst edge cnt",  32'(dut.cnt), 1);
        check("post rst edge busy", 32'(a_busy),  1);
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
